// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core. o_state encoding: 0 Fetch, 1 Decode, 2 ExecR,
// 3 ExecI, 4 Addr, 5 MemRd, 6 MemWr, 7 WbAlu, 8 WbMem, 9 Branch, 10 Error.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_instr,
  input  logic             i_alu_zero,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_ir_we,
  output logic             o_pc_we,
  output logic             o_pc_src,
  output logic             o_reg_we,
  output logic             o_wb_sel,
  output logic             o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic [1:0]       o_imm_sel,
  output logic             o_illegal,
  output logic             o_bus_err,
  output logic [CNT_W-1:0] o_instr_count,
  output logic [3:0]       o_state
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExecR  = 4'd2,
    StExecI  = 4'd3,
    StAddr   = 4'd4,
    StMemRd  = 4'd5,
    StMemWr  = 4'd6,
    StWbAlu  = 4'd7,
    StWbMem  = 4'd8,
    StBranch = 4'd9,
    StError  = 4'd10
  } state_e;

  state_e           r_state;
  state_e           w_next;
  logic [WaitW-1:0] r_wait;
  logic [WaitW-1:0] w_wait_inc;
  logic [CNT_W-1:0] r_count;
  logic             r_bus_err;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_is_r;
  logic       w_is_i;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_branch;
  logic       w_legal;
  logic       w_take;
  logic       w_mem_state;
  logic       w_timeout;
  logic       w_retire;
  logic       w_unused_instr;

  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_ir_we;
  logic       w_pc_we;
  logic       w_pc_src;
  logic       w_reg_we;
  logic       w_wb_sel;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_imm_sel;
  logic       w_illegal;

  // Only opcode and funct3 steer the sequence; the rest of the IR feeds the datapath.
  assign w_opcode       = i_instr[6:0];
  assign w_funct3       = i_instr[14:12];
  assign w_unused_instr = ^{i_instr[31:15], i_instr[11:7]};

  assign w_is_r      = (w_opcode == OpR);
  assign w_is_i      = (w_opcode == OpImm);
  assign w_is_load   = (w_opcode == OpLoad);
  assign w_is_store  = (w_opcode == OpStore);
  assign w_is_branch = (w_opcode == OpBranch) && (w_funct3 == 3'b000 || w_funct3 == 3'b001);
  assign w_legal     = w_is_r || w_is_i || w_is_load || w_is_store || w_is_branch;
  assign w_take      = (w_funct3 == 3'b000) ? i_alu_zero : ~i_alu_zero;

  assign w_mem_state = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
  assign w_wait_inc  = r_wait + 1'b1;
  assign w_timeout   = w_mem_state && !i_mem_ready && (w_wait_inc == WaitW'(TIMEOUT));

  assign w_retire = (r_state == StWbAlu) || (r_state == StWbMem) || (r_state == StBranch) ||
                    ((r_state == StMemWr) && i_mem_ready);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StFetch: if (i_mem_ready) w_next = StDecode;
      StDecode: begin
        if (w_is_r)                        w_next = StExecR;
        else if (w_is_i)                   w_next = StExecI;
        else if (w_is_load || w_is_store)  w_next = StAddr;
        else if (w_is_branch)              w_next = StBranch;
        else                               w_next = StFetch;
      end
      StExecR:  w_next = StWbAlu;
      StExecI:  w_next = StWbAlu;
      StAddr:   w_next = w_is_store ? StMemWr : StMemRd;
      StMemRd:  if (i_mem_ready) w_next = StWbMem;
      StMemWr:  if (i_mem_ready) w_next = StFetch;
      StWbAlu:  w_next = StFetch;
      StWbMem:  w_next = StFetch;
      StBranch: w_next = StFetch;
      StError:  w_next = StError;
      default:  w_next = StFetch;
    endcase
    if (w_timeout) w_next = StError;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StFetch;
      r_wait    <= '0;
      r_count   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if (w_mem_state && !i_mem_ready) begin
        r_wait <= w_wait_inc;
      end
      if (w_retire) begin
        r_count <= r_count + 1'b1;
      end
      if (w_next == StError) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_ir_we     = 1'b0;
    w_pc_we     = 1'b0;
    w_pc_src    = 1'b0;
    w_reg_we    = 1'b0;
    w_wb_sel    = 1'b0;
    w_alu_src_a = 1'b0;
    w_alu_src_b = 2'b00;
    w_alu_op    = 2'b00;
    w_imm_sel   = 2'b00;
    w_illegal   = 1'b0;
    unique case (r_state)
      StFetch: begin
        w_mem_req   = 1'b1;
        w_alu_src_b = 2'b10;
        w_ir_we     = i_mem_ready;
        w_pc_we     = i_mem_ready;
      end
      StDecode: begin
        // Branch target is precomputed here into ALUOut.
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b01;
        w_imm_sel   = 2'b10;
        w_illegal   = ~w_legal;
      end
      StExecR: begin
        w_alu_op  = 2'b10;
        w_imm_sel = 2'b11;
      end
      StExecI: begin
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
      end
      StAddr: begin
        w_alu_src_b = 2'b01;
        w_imm_sel   = w_is_store ? 2'b01 : 2'b00;
      end
      StMemRd: w_mem_req = 1'b1;
      StMemWr: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
      end
      StWbAlu: w_reg_we = 1'b1;
      StWbMem: begin
        w_reg_we = 1'b1;
        w_wb_sel = 1'b1;
      end
      StBranch: begin
        w_alu_op = 2'b01;
        w_pc_src = 1'b1;
        w_pc_we  = w_take;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset so an in-flight write drops without waiting for a clock.
  assign o_mem_req     = w_mem_req & i_rst_n;
  assign o_mem_we      = w_mem_we & i_rst_n;
  assign o_ir_we       = w_ir_we & i_rst_n;
  assign o_pc_we       = w_pc_we & i_rst_n;
  assign o_pc_src      = w_pc_src & i_rst_n;
  assign o_reg_we      = w_reg_we & i_rst_n;
  assign o_wb_sel      = w_wb_sel & i_rst_n;
  assign o_alu_src_a   = w_alu_src_a & i_rst_n;
  assign o_alu_src_b   = w_alu_src_b & {2{i_rst_n}};
  assign o_alu_op      = w_alu_op & {2{i_rst_n}};
  assign o_imm_sel     = w_imm_sel & {2{i_rst_n}};
  assign o_illegal     = w_illegal & i_rst_n;
  assign o_bus_err     = r_bus_err;
  assign o_instr_count = r_count;
  assign o_state       = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, multi-cycle corner sequences and random
// instruction streams checked against an instruction-level reference model.
module tb_multicycle_ctrl;

  localparam int unsigned CW = 8;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_MEM_WR = 4'd6;
  localparam logic [3:0] S_WB_ALU = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_ERROR  = 4'd10;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [31:0] R_ADD = 32'h0000_0033;
  localparam logic [31:0] LD    = 32'h0070_2083;
  localparam logic [31:0] ST    = 32'hE070_2023;
  localparam logic [31:0] BEQ   = 32'h0000_0163;
  localparam logic [31:0] BNE   = 32'h0000_1163;
  localparam logic [31:0] ILL   = 32'h0000_007F;
  localparam logic [31:0] ADDI  = 32'h0050_0093;
  localparam logic [31:0] BILL  = 32'h0000_2063;

  logic          clk;
  logic          rst_n;
  logic [31:0]   instr;
  logic          alu_zero;
  logic          mem_ready;
  logic          mem_req;
  logic          mem_we;
  logic          ir_we;
  logic          pc_we;
  logic          pc_src;
  logic          reg_we;
  logic          wb_sel;
  logic          alu_src_a;
  logic [1:0]    alu_src_b;
  logic [1:0]    alu_op;
  logic [1:0]    imm_sel;
  logic          illegal;
  logic          bus_err;
  logic [CW-1:0] instr_count;
  logic [3:0]    state;

  multicycle_ctrl #(
    .TIMEOUT(16),
    .CNT_W  (CW)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_instr      (instr),
    .i_alu_zero   (alu_zero),
    .i_mem_ready  (mem_ready),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_ir_we      (ir_we),
    .o_pc_we      (pc_we),
    .o_pc_src     (pc_src),
    .o_reg_we     (reg_we),
    .o_wb_sel     (wb_sel),
    .o_alu_src_a  (alu_src_a),
    .o_alu_src_b  (alu_src_b),
    .o_alu_op     (alu_op),
    .o_imm_sel    (imm_sel),
    .o_illegal    (illegal),
    .o_bus_err    (bus_err),
    .o_instr_count(instr_count),
    .o_state      (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] st;
    logic       req;
    logic       we;
    logic       irwe;
    logic       pcwe;
    logic       pcsrc;
    logic       regwe;
    logic       wbsel;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [1:0] imm;
    logic       ill;
    logic       berr;
  } outs_t;

  typedef struct {
    logic [31:0] ins;
    logic        z;
    logic        r;
    int unsigned cnt;
    outs_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic outs_t mk(input logic [3:0] st, input logic req, we, irwe, pcwe, pcsrc,
                               regwe, wbsel, srca, input logic [1:0] srcb, aluop, imm,
                               input logic ill);
    outs_t o;
    o.st = st;  o.req = req;  o.we = we;  o.irwe = irwe;  o.pcwe = pcwe;  o.pcsrc = pcsrc;
    o.regwe = regwe;  o.wbsel = wbsel;  o.srca = srca;  o.srcb = srcb;  o.aluop = aluop;
    o.imm = imm;  o.ill = ill;  o.berr = 1'b0;
    return o;
  endfunction

  function automatic outs_t f_fetch(input logic r);
    return mk(S_FETCH, 1, 0, r, r, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0);
  endfunction

  function automatic outs_t f_dec(input logic ill);
    return mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b10, ill);
  endfunction

  function automatic outs_t dut_outs();
    outs_t o;
    o.st = state;  o.req = mem_req;  o.we = mem_we;  o.irwe = ir_we;  o.pcwe = pc_we;
    o.pcsrc = pc_src;  o.regwe = reg_we;  o.wbsel = wb_sel;  o.srca = alu_src_a;
    o.srcb = alu_src_b;  o.aluop = alu_op;  o.imm = imm_sel;  o.ill = illegal;
    o.berr = bus_err;
    return o;
  endfunction

  function automatic logic legal(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) ||
           ((op == OP_BR) && (ins[14:13] == 2'b00));
  endfunction

  // Expected strobes for one cycle spent in state s, straight from the control table.
  function automatic outs_t exp_outs(input logic [3:0] s, input logic [31:0] ins, input logic z,
                                     input logic r);
    outs_t o;
    o = '0;
    o.st = s;
    case (s)
      S_FETCH:  begin o.req = 1'b1; o.srcb = 2'b10; o.irwe = r; o.pcwe = r; end
      S_DECODE: begin o.srca = 1'b1; o.srcb = 2'b01; o.imm = 2'b10; o.ill = !legal(ins); end
      S_EXEC_R: begin o.aluop = 2'b10; o.imm = 2'b11; end
      S_EXEC_I: begin o.srcb = 2'b01; o.aluop = 2'b10; end
      S_ADDR:   begin o.srcb = 2'b01; o.imm = (ins[6:0] == OP_ST) ? 2'b01 : 2'b00; end
      S_MEM_RD: o.req = 1'b1;
      S_MEM_WR: begin o.req = 1'b1; o.we = 1'b1; end
      S_WB_ALU: o.regwe = 1'b1;
      S_WB_MEM: begin o.regwe = 1'b1; o.wbsel = 1'b1; end
      S_BRANCH: begin
        o.aluop = 2'b01;
        o.pcsrc = 1'b1;
        o.pcwe  = (ins[14:12] == 3'b000) ? z : !z;
      end
      S_ERROR:  o.berr = 1'b1;
      default:  ;
    endcase
    return o;
  endfunction

  task automatic chk_outs(input string name, input outs_t want);
    outs_t got;
    got = dut_outs();
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: outputs got %05h want %05h", name, got, want);
  endtask

  task automatic chk_val(input string name, input int unsigned got, input int unsigned want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  task automatic cyc(input string name, input logic [31:0] ins, input logic z, input logic r,
                     input outs_t want, input int unsigned cnt);
    instr = ins;
    alu_zero = z;
    mem_ready = r;
    #2;
    chk_outs(name, want);
    chk_val({name, " count"}, 32'(instr_count), cnt % (1 << CW));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    alu_zero = 1'b1;
    instr = R_ADD;
    #2;
    chk_outs("reset", '0);
    chk_val("reset count", 32'(instr_count), 0);
    @(posedge clk);
    #1;
    chk_outs("reset held", '0);
    rst_n = 1'b1;
  endtask

  task automatic add(input logic [31:0] ins, input logic z, input logic r, input int unsigned cnt,
                     input outs_t e);
    vec_t v;
    v.ins = ins;  v.z = z;  v.r = r;  v.cnt = cnt;  v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    add(R_ADD, 0, 1, 0, f_fetch(1));
    add(R_ADD, 0, 0, 0, f_dec(0));
    add(R_ADD, 1, 1, 0, mk(S_EXEC_R, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b11, 0));
    add(R_ADD, 0, 1, 0, mk(S_WB_ALU, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    add(ST, 0, 1, 1, f_fetch(1));
    add(ST, 0, 1, 1, f_dec(0));
    add(ST, 0, 0, 1, mk(S_ADDR, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 0));
    add(ST, 0, 1, 1, mk(S_MEM_WR, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    add(LD, 0, 1, 2, f_fetch(1));
    add(LD, 0, 1, 2, f_dec(0));
    add(LD, 0, 1, 2, mk(S_ADDR, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    for (int k = 0; k < 3; k++)
      add(LD, 0, 0, 2, mk(S_MEM_RD, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    add(LD, 0, 1, 2, mk(S_MEM_RD, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    add(LD, 0, 0, 2, mk(S_WB_MEM, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0));
    add(BEQ, 1, 1, 3, f_fetch(1));
    add(BEQ, 1, 1, 3, f_dec(0));
    add(BEQ, 1, 1, 3, mk(S_BRANCH, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0));
    add(BEQ, 0, 1, 4, f_fetch(1));
    add(BEQ, 0, 1, 4, f_dec(0));
    add(BEQ, 0, 1, 4, mk(S_BRANCH, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0));
    add(BNE, 0, 1, 5, f_fetch(1));
    add(BNE, 0, 1, 5, f_dec(0));
    add(BNE, 0, 1, 5, mk(S_BRANCH, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0));
    add(BNE, 1, 1, 6, f_fetch(1));
    add(BNE, 1, 1, 6, f_dec(0));
    add(BNE, 1, 1, 6, mk(S_BRANCH, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0));
    add(ILL, 0, 1, 7, f_fetch(1));
    add(ILL, 0, 1, 7, f_dec(1));
    add(ADDI, 0, 1, 7, f_fetch(1));
    add(ADDI, 0, 1, 7, f_dec(0));
    add(ADDI, 0, 1, 7, mk(S_EXEC_I, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 0));
    add(ADDI, 0, 0, 7, mk(S_WB_ALU, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    add(BILL, 0, 0, 8, f_fetch(0));
    add(BILL, 0, 1, 8, f_fetch(1));
    add(BILL, 0, 0, 8, f_dec(1));
    add(BILL, 0, 0, 8, f_fetch(0));
  endtask

  // Reference model: each instruction class maps to a fixed list of control steps; memory
  // steps stall for a random number of not-ready cycles below the timeout.
  task automatic run_random(input int n);
    int unsigned cnt;
    int unsigned cls;
    int unsigned d;
    logic [31:0] ins;
    logic [2:0]  f3;
    logic        z;
    logic        r;
    logic [3:0]  seq[$];
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      cls = $urandom_range(0, 7);
      ins = $urandom;
      case (cls)
        0: ins[6:0] = OP_R;
        1: ins[6:0] = OP_I;
        2: ins[6:0] = OP_LD;
        3: ins[6:0] = OP_ST;
        4: begin ins[6:0] = OP_BR; ins[14:12] = 3'b000; end
        5: begin ins[6:0] = OP_BR; ins[14:12] = 3'b001; end
        6: if (ins[6:0] inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR}) ins[6:0] = 7'h7F;
        default: begin
          f3 = 3'($urandom_range(2, 7));
          ins[6:0] = OP_BR;
          ins[14:12] = f3;
        end
      endcase
      seq.delete();
      seq.push_back(S_FETCH);
      seq.push_back(S_DECODE);
      case (cls)
        0: begin seq.push_back(S_EXEC_R); seq.push_back(S_WB_ALU); end
        1: begin seq.push_back(S_EXEC_I); seq.push_back(S_WB_ALU); end
        2: begin seq.push_back(S_ADDR); seq.push_back(S_MEM_RD); seq.push_back(S_WB_MEM); end
        3: begin seq.push_back(S_ADDR); seq.push_back(S_MEM_WR); end
        4, 5: seq.push_back(S_BRANCH);
        default: ;
      endcase
      for (int j = 0; j < seq.size(); j++) begin
        z = 1'($urandom);
        if (seq[j] == S_FETCH || seq[j] == S_MEM_RD || seq[j] == S_MEM_WR) begin
          d = ($urandom_range(0, 19) == 0) ? 15 : $urandom_range(0, 3);
          repeat (d)
            cyc($sformatf("rand i%0d wait st%0d", k, seq[j]), ins, z, 1'b0,
                exp_outs(seq[j], ins, z, 1'b0), cnt);
          r = 1'b1;
        end else begin
          r = 1'($urandom);
        end
        cyc($sformatf("rand i%0d st%0d", k, seq[j]), ins, z, r, exp_outs(seq[j], ins, z, r), cnt);
      end
      if (cls < 6) cnt++;
    end
    #2;
    chk_val("rand final count", 32'(instr_count), cnt % (1 << CW));
  endtask

  initial begin
    rst_n = 1'b1;
    instr = R_ADD;
    alu_zero = 1'b0;
    mem_ready = 1'b0;
    #1;
    build_table();
    reset_dut();
    for (int k = 0; k < vecs.size(); k++)
      cyc($sformatf("vec%0d", k), vecs[k].ins, vecs[k].z, vecs[k].r, vecs[k].exp, vecs[k].cnt);

    // Load stalled one cycle short of the timeout must still complete.
    reset_dut();
    cyc("A fetch", LD, 0, 1, exp_outs(S_FETCH, LD, 0, 1), 0);
    cyc("A decode", LD, 0, 0, exp_outs(S_DECODE, LD, 0, 0), 0);
    cyc("A addr", LD, 0, 0, exp_outs(S_ADDR, LD, 0, 0), 0);
    for (int k = 0; k < 15; k++) cyc("A wait", LD, 0, 0, exp_outs(S_MEM_RD, LD, 0, 0), 0);
    cyc("A ready", LD, 0, 1, exp_outs(S_MEM_RD, LD, 0, 1), 0);
    cyc("A wb", LD, 0, 0, exp_outs(S_WB_MEM, LD, 0, 0), 0);

    // Sixteen not-ready cycles in fetch: bus error, sticky, ready then ignored.
    for (int k = 0; k < 16; k++) cyc("B wait", R_ADD, 0, 0, exp_outs(S_FETCH, R_ADD, 0, 0), 1);
    for (int k = 0; k < 3; k++) cyc("B error", R_ADD, 0, 1, exp_outs(S_ERROR, R_ADD, 0, 1), 1);

    // Reset during a store write drops mem_we immediately and clears the counter.
    reset_dut();
    cyc("C fetch", R_ADD, 0, 1, exp_outs(S_FETCH, R_ADD, 0, 1), 0);
    cyc("C decode", R_ADD, 0, 1, exp_outs(S_DECODE, R_ADD, 0, 1), 0);
    cyc("C exec", R_ADD, 0, 1, exp_outs(S_EXEC_R, R_ADD, 0, 1), 0);
    cyc("C wb", R_ADD, 0, 1, exp_outs(S_WB_ALU, R_ADD, 0, 1), 0);
    cyc("C st fetch", ST, 0, 1, exp_outs(S_FETCH, ST, 0, 1), 1);
    cyc("C st decode", ST, 0, 1, exp_outs(S_DECODE, ST, 0, 1), 1);
    cyc("C st addr", ST, 0, 1, exp_outs(S_ADDR, ST, 0, 1), 1);
    instr = ST;
    mem_ready = 1'b0;
    #2;
    chk_outs("C memwr", exp_outs(S_MEM_WR, ST, 0, 0));
    #1;
    rst_n = 1'b0;
    #1;
    chk_outs("C reset mid", '0);
    chk_val("C reset count", 32'(instr_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("C after", R_ADD, 0, 1, exp_outs(S_FETCH, R_ADD, 0, 1), 0);

    reset_dut();
    run_random(500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
